// File: rtl/kf_spi_pkg.sv
// Shared types and helpers for the SPI-side sequencer feeding the Kalman-filter core.
package kf_spi_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CFG_SHIFT = 4'd1,
        ST_CFG_STORE = 4'd2,
        ST_OUT_LOAD  = 4'd3,
        ST_OUT_SHIFT = 4'd4,
        ST_DONE      = 4'd5,
        ST_ABORT     = 4'd6
    } kf_spi_state_t;

    // Address widths never collapse to zero bits, even for a single word.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kf_edge_counter.sv
// Counts SCLK edge strobes within one word; flags the strobe that completes DATA_W edges.
module kf_edge_counter #(
    parameter int DATA_W = 16
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic strobe,
    output logic rollover
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (strobe) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // High on the edge that brings the count to DATA_W.
    assign rollover = strobe && !clr && (count_reg == LAST_CNT);

endmodule

// File: rtl/kf_spi_sequencer.sv
// Frames the configuration burst into the register map and paces result words to the
// output PTS register, with abort on slave-select loss and a reconfiguration request.
module kf_spi_sequencer
    import kf_spi_pkg::*;
#(
    parameter int  DATA_W  = 16,
    parameter int  NUM_CFG = 5,
    parameter int  NUM_OUT = 3,
    localparam int CFG_AW  = clog2_min1(NUM_CFG),
    localparam int OUT_AW  = clog2_min1(NUM_OUT)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              sclk_rise,
    input  logic              sclk_fall,
    input  logic              ss_active,
    input  logic              mosi,
    input  logic              write_enable,
    input  logic              reconfig_req,
    output logic [DATA_W-1:0] cfg_word,
    output logic [CFG_AW-1:0] cfg_addr,
    output logic              cfg_wr,
    output logic              configured,
    output logic              out_load,
    output logic [OUT_AW-1:0] out_idx,
    output logic              output_ready,
    output logic              done,
    output logic              err_abort
);

    localparam int IDX_W = (CFG_AW > OUT_AW) ? CFG_AW : OUT_AW;
    localparam logic [IDX_W-1:0] CFG_LAST = IDX_W'(NUM_CFG - 1);
    localparam logic [IDX_W-1:0] OUT_LAST = IDX_W'(NUM_OUT - 1);

    kf_spi_state_t     state_reg;
    logic [DATA_W-1:0] shreg_reg;
    logic [IDX_W-1:0]  word_idx_reg;
    logic              edge_strobe;
    logic              cnt_clr;
    logic              rollover;

    // Only the edge polarity relevant to the current direction reaches the counter.
    assign edge_strobe = ((state_reg == ST_CFG_SHIFT) && sclk_rise) ||
                         ((state_reg == ST_OUT_SHIFT) && sclk_fall);
    assign cnt_clr     = !((state_reg == ST_CFG_SHIFT) || (state_reg == ST_OUT_SHIFT));

    kf_edge_counter #(
        .DATA_W (DATA_W)
    ) u_edge_counter (
        .clk      (clk),
        .n_rst    (n_rst),
        .clr      (cnt_clr),
        .strobe   (edge_strobe),
        .rollover (rollover)
    );

    // shreg holds steady for the whole store cycle, so the word is qualified by cfg_wr.
    assign cfg_word = cfg_wr ? shreg_reg : '0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg    <= ST_IDLE;
            shreg_reg    <= '0;
            word_idx_reg <= '0;
            configured   <= 1'b0;
            cfg_addr     <= '0;
            cfg_wr       <= 1'b0;
            out_load     <= 1'b0;
            out_idx      <= '0;
            output_ready <= 1'b0;
            done         <= 1'b0;
            err_abort    <= 1'b0;
        end else begin
            cfg_wr       <= 1'b0;
            cfg_addr     <= '0;
            out_load     <= 1'b0;
            out_idx      <= '0;
            output_ready <= 1'b0;
            done         <= 1'b0;
            err_abort    <= 1'b0;

            if (!ss_active && (state_reg inside {ST_CFG_SHIFT, ST_CFG_STORE,
                                                 ST_OUT_LOAD, ST_OUT_SHIFT})) begin
                state_reg <= ST_ABORT;
                err_abort <= 1'b1;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (reconfig_req) begin
                            configured <= 1'b0;
                        end else if (ss_active && sclk_rise && mosi && !configured) begin
                            state_reg <= ST_CFG_SHIFT;
                        end else if (ss_active && write_enable && configured) begin
                            state_reg <= ST_OUT_LOAD;
                            out_load  <= 1'b1;
                            out_idx   <= OUT_AW'(word_idx_reg);
                        end
                    end
                    ST_CFG_SHIFT: begin
                        if (sclk_rise) begin
                            shreg_reg <= {shreg_reg[DATA_W-2:0], mosi};
                        end
                        if (rollover) begin
                            state_reg <= ST_CFG_STORE;
                            cfg_wr    <= 1'b1;
                            cfg_addr  <= CFG_AW'(word_idx_reg);
                        end
                    end
                    ST_CFG_STORE: begin
                        if (word_idx_reg == CFG_LAST) begin
                            configured   <= 1'b1;
                            word_idx_reg <= '0;
                            state_reg    <= ST_IDLE;
                        end else begin
                            word_idx_reg <= word_idx_reg + IDX_W'(1);
                            state_reg    <= ST_CFG_SHIFT;
                        end
                    end
                    ST_OUT_LOAD: begin
                        state_reg    <= ST_OUT_SHIFT;
                        output_ready <= 1'b1;
                    end
                    ST_OUT_SHIFT: begin
                        if (!rollover) begin
                            output_ready <= 1'b1;
                        end else if (word_idx_reg == OUT_LAST) begin
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
                        end else begin
                            word_idx_reg <= word_idx_reg + IDX_W'(1);
                            state_reg    <= ST_OUT_LOAD;
                            out_load     <= 1'b1;
                            out_idx      <= OUT_AW'(word_idx_reg + IDX_W'(1));
                        end
                    end
                    ST_DONE: begin
                        word_idx_reg <= '0;
                        state_reg    <= ST_IDLE;
                    end
                    ST_ABORT: begin
                        word_idx_reg <= '0;
                        shreg_reg    <= '0;
                        state_reg    <= ST_IDLE;
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
